// File: rtl/reg_wb_arbiter_pkg.sv
// Shared register-file defines plus small helpers for the write-back arbiter.
//   WORD_LEN          register data width
//   REG_32_ADDR_LEN   register address width
//   REG_32_TOTALSIZE  number of architectural registers
package reg_wb_arbiter_pkg;

    localparam int WORD_LEN         = 32;
    localparam int REG_32_ADDR_LEN  = 5;
    localparam int REG_32_TOTALSIZE = 1 << REG_32_ADDR_LEN;

    // Round-robin successor: wraps idx back to 0 after the last requester.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Write-back request bundle shared by the requesters and the arbiter.
//   i_req_valid  per-requester request
//   i_req_addr   packed destination addresses, requester k at slice k
//   i_req_data   packed write data, requester k at slice k
//   o_req_ready  one-hot accept from the arbiter
// master = requester side, slave = arbiter side.
interface reg_wb_arbiter_if
    import reg_wb_arbiter_pkg::*;
#(
    parameter int N_REQ           = 3,
    parameter int WORD_LEN        = reg_wb_arbiter_pkg::WORD_LEN,
    parameter int REG_32_ADDR_LEN = reg_wb_arbiter_pkg::REG_32_ADDR_LEN
);

    logic [N_REQ-1:0]                 i_req_valid;
    logic [N_REQ*REG_32_ADDR_LEN-1:0] i_req_addr;
    logic [N_REQ*WORD_LEN-1:0]        i_req_data;
    logic [N_REQ-1:0]                 o_req_ready;

    modport master (
        output i_req_valid,
        output i_req_addr,
        output i_req_data,
        input  o_req_ready
    );

    modport slave (
        input  i_req_valid,
        input  i_req_addr,
        input  i_req_data,
        output o_req_ready
    );

endinterface

// File: rtl/reg_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   valid      request vector
//   rr_ptr     index where the search starts
//   grant      one-hot grant (zero when nothing is valid)
//   grant_idx  index of the granted requester
//   grant_any  some requester was granted
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // Wrap (rr_ptr + i) without a modulo operator; rr_ptr < N_REQ always.
            cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand_sum >= (IDX_W+1)'(N_REQ)) begin
                cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!grant_any && valid[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter with destination scoreboard.
//   i_sys_clk, i_sys_rst_n         clock, async active-low reset
//   wb (slave)                     requester valid/addr/data in, one-hot ready out
//   o_dest_write_en/addr/write_val registered register-file write port (latency 1)
//   i_claim_en, i_claim_addr       issue stage marks a destination pending
//   i_src_addr_1/2, o_src_busy_1/2 hazard query against the pending bits
//   i_flush                        clear all pending bits
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int WORD_LEN        = reg_wb_arbiter_pkg::WORD_LEN,
    parameter int REG_32_ADDR_LEN = reg_wb_arbiter_pkg::REG_32_ADDR_LEN,
    parameter int N_REQ           = 3
) (
    input  logic                       i_sys_clk,
    input  logic                       i_sys_rst_n,
    reg_wb_arbiter_if.slave            wb,
    output logic                       o_dest_write_en,
    output logic [REG_32_ADDR_LEN-1:0] o_dest_addr,
    output logic [WORD_LEN-1:0]        o_dest_write_val,
    input  logic                       i_claim_en,
    input  logic [REG_32_ADDR_LEN-1:0] i_claim_addr,
    input  logic [REG_32_ADDR_LEN-1:0] i_src_addr_1,
    input  logic [REG_32_ADDR_LEN-1:0] i_src_addr_2,
    output logic                       o_src_busy_1,
    output logic                       o_src_busy_2,
    input  logic                       i_flush
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int N_REGS = 1 << REG_32_ADDR_LEN;

    logic [IDX_W-1:0]           rr_ptr;
    logic [IDX_W-1:0]           grant_idx;
    logic [N_REQ-1:0]           grant;
    logic                       grant_any;
    logic                       transfer;
    logic [REG_32_ADDR_LEN-1:0] acc_addr;
    logic [WORD_LEN-1:0]        acc_data;
    logic [N_REGS-1:0]          pending_q;
    logic [N_REGS-1:0]          pending_d;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .valid     (wb.i_req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Ready is forced low during reset so nothing is accepted and then dropped.
    assign wb.o_req_ready = i_sys_rst_n ? grant : '0;
    assign transfer       = grant_any & i_sys_rst_n;

    always_comb begin
        acc_addr = '0;
        acc_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                acc_addr = wb.i_req_addr[k*REG_32_ADDR_LEN +: REG_32_ADDR_LEN];
                acc_data = wb.i_req_data[k*WORD_LEN +: WORD_LEN];
            end
        end
    end

    // Order matters: claim is applied after the write-back clear so it wins,
    // and flush overrides both. Register 0 is never pending.
    always_comb begin
        pending_d = pending_q;
        if (transfer) begin
            pending_d[acc_addr] = 1'b0;
        end
        if (i_claim_en) begin
            pending_d[i_claim_addr] = 1'b1;
        end
        if (i_flush) begin
            pending_d = '0;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            o_dest_write_en  <= 1'b0;
            o_dest_addr      <= '0;
            o_dest_write_val <= '0;
            rr_ptr           <= '0;
            pending_q        <= '0;
        end else begin
            // Writes to $zero are acknowledged but never reach the register file.
            o_dest_write_en <= transfer && (acc_addr != '0);
            if (transfer) begin
                o_dest_addr      <= acc_addr;
                o_dest_write_val <= acc_data;
                rr_ptr           <= IDX_W'(rr_next(32'(grant_idx), N_REQ));
            end
            pending_q <= pending_d;
        end
    end

    // No bypass: a register being written back this cycle still reads busy.
    assign o_src_busy_1 = pending_q[i_src_addr_1];
    assign o_src_busy_2 = pending_q[i_src_addr_2];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        dest_we;
    logic [4:0]  dest_addr;
    logic [31:0] dest_val;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic        busy1;
    logic        busy2;
    logic        flush;

    logic        rq_valid [3];
    logic [4:0]  rq_addr  [3];
    logic [31:0] rq_data  [3];

    int          m_rr;
    bit   [31:0] m_pend;
    int          last_grant;
    exp_t        sb_q [$];

    int n_checks;
    int n_fail;

    reg_wb_arbiter_if #(.N_REQ(3), .WORD_LEN(32), .REG_32_ADDR_LEN(5)) wb_if ();

    reg_wb_arbiter #(
        .WORD_LEN        (32),
        .REG_32_ADDR_LEN (5),
        .N_REQ           (3)
    ) dut (
        .i_sys_clk        (clk),
        .i_sys_rst_n      (rst_n),
        .wb               (wb_if),
        .o_dest_write_en  (dest_we),
        .o_dest_addr      (dest_addr),
        .o_dest_write_val (dest_val),
        .i_claim_en       (claim_en),
        .i_claim_addr     (claim_addr),
        .i_src_addr_1     (src1),
        .i_src_addr_2     (src2),
        .o_src_busy_1     (busy1),
        .o_src_busy_2     (busy2),
        .i_flush          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic apply_reqs();
        for (int k = 0; k < 3; k++) begin
            wb_if.i_req_valid[k]         = rq_valid[k];
            wb_if.i_req_addr[k*5 +: 5]   = rq_addr[k];
            wb_if.i_req_data[k*32 +: 32] = rq_data[k];
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic [4:0] a, input logic [31:0] d);
        rq_valid[k] = v;
        rq_addr[k]  = a;
        rq_data[k]  = d;
        apply_reqs();
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < 3; k++) begin
            rq_valid[k] = 1'b0;
        end
        apply_reqs();
    endtask

    // One clock: check combinational outputs at negedge against the model,
    // queue the expected write, then check the registered write after posedge.
    task automatic tick();
        exp_t       e;
        int         g;
        int         c;
        logic [2:0] exp_rdy;
        @(negedge clk);
        g = -1;
        for (int i = 0; i < 3; i++) begin
            c = (m_rr + i) % 3;
            if (g < 0 && rq_valid[c]) g = c;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_val("ready", wb_if.o_req_ready, exp_rdy);
        check_val("busy_1", busy1, m_pend[src1]);
        check_val("busy_2", busy2, m_pend[src2]);
        e.we   = (g >= 0) && (rq_addr[g] != 5'd0);
        e.addr = (g >= 0) ? rq_addr[g] : 5'd0;
        e.data = (g >= 0) ? rq_data[g] : 32'd0;
        sb_q.push_back(e);
        if (g >= 0) begin
            m_rr = (g + 1) % 3;
            m_pend[rq_addr[g]] = 1'b0;
        end
        if (claim_en && claim_addr != 5'd0) m_pend[claim_addr] = 1'b1;
        if (flush) m_pend = '0;
        last_grant = g;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val("write_en", dest_we, e.we);
        if (e.we) begin
            check_val("dest_addr", dest_addr, e.addr);
            check_val("dest_val", dest_val, e.data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        m_rr       = 0;
        m_pend     = '0;
        last_grant = -1;
        rst_n      = 1'b0;
        claim_en   = 1'b0;
        claim_addr = '0;
        src1       = 5'd3;
        src2       = 5'd9;
        flush      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rq_valid[k] = 1'b0;
            rq_addr[k]  = '0;
            rq_data[k]  = '0;
        end
        apply_reqs();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        set_req(0, 1'b1, 5'd1, 32'h11);
        set_req(1, 1'b1, 5'd2, 32'h22);
        set_req(2, 1'b1, 5'd3, 32'h33);
        #1;
        check_val("rst_ready", wb_if.o_req_ready, 3'b000);
        check_val("rst_we", dest_we, 1'b0);
        check_val("rst_addr", dest_addr, 5'd0);
        check_val("rst_val", dest_val, 32'd0);
        clear_reqs();
        rst_n = 1'b1;
        #1;
        check_val("rst_busy_1", busy1, 1'b0);
        check_val("rst_busy_2", busy2, 1'b0);

        // Round-robin with all three valid: 0,1,2,0
        for (int k = 0; k < 3; k++) set_req(k, 1'b1, 5'(k + 1), 32'hA0 + 32'(k));
        repeat (4) tick();
        clear_reqs();
        tick();

        // Single requester 2
        set_req(2, 1'b1, 5'd7, 32'hDEADBEEF);
        tick();
        clear_reqs();
        tick();

        // Claim 9, busy until its write-back is accepted
        claim_en = 1'b1; claim_addr = 5'd9; src1 = 5'd9;
        tick();
        claim_en = 1'b0;
        repeat (2) tick();
        set_req(0, 1'b1, 5'd9, 32'h99);
        tick();
        clear_reqs();
        tick();

        // Claim and write-back of 4 in the same cycle: claim wins
        claim_en = 1'b1; claim_addr = 5'd4; src2 = 5'd4;
        set_req(1, 1'b1, 5'd4, 32'h44);
        tick();
        claim_en = 1'b0;
        clear_reqs();
        tick();

        // Write to $zero is acknowledged but suppressed; claim of 0 ignored
        set_req(0, 1'b1, 5'd0, 32'h5);
        tick();
        clear_reqs();
        claim_en = 1'b1; claim_addr = 5'd0; src1 = 5'd0;
        tick();
        claim_en = 1'b0;
        tick();

        // Flush drops the same-cycle claim but keeps the transfer
        claim_en = 1'b1; claim_addr = 5'd10; src1 = 5'd10; flush = 1'b1;
        set_req(2, 1'b1, 5'd6, 32'h66);
        tick();
        claim_en = 1'b0; flush = 1'b0;
        clear_reqs();
        tick();

        // Random traffic; a requester holds its request until granted
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (!rq_valid[k] || last_grant == k) begin
                    rq_valid[k] = 1'($urandom_range(0, 1));
                    rq_addr[k]  = 5'($urandom_range(0, 15));
                    rq_data[k]  = $urandom;
                end
            end
            apply_reqs();
            claim_en   = 1'($urandom_range(0, 1));
            claim_addr = 5'($urandom_range(0, 15));
            src1       = 5'($urandom_range(0, 15));
            src2       = 5'($urandom_range(0, 15));
            flush      = ($urandom_range(0, 15) == 0);
            tick();
        end
        clear_reqs();
        claim_en = 1'b0;
        flush    = 1'b0;
        tick();

        // Reset between clocks with a write in flight and a pending claim
        claim_en = 1'b1; claim_addr = 5'd13; src1 = 5'd13;
        set_req(1, 1'b1, 5'd12, 32'hC0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_we", dest_we, 1'b0);
        check_val("arst_addr", dest_addr, 5'd0);
        check_val("arst_val", dest_val, 32'd0);
        check_val("arst_busy_1", busy1, 1'b0);
        check_val("arst_ready", wb_if.o_req_ready, 3'b000);
        claim_en = 1'b0;
        clear_reqs();
        #1;
        rst_n  = 1'b1;
        m_rr   = 0;
        m_pend = '0;
        sb_q.delete();
        tick();
        for (int k = 0; k < 3; k++) set_req(k, 1'b1, 5'(k + 20), 32'hB0 + 32'(k));
        repeat (2) tick();
        clear_reqs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
